// File: rtl/axil_arb_defs.sv
// Shared encodings for the two-master AXI4-Lite memory arbiter.
package axil_arb_defs;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_RESP,
    WR_XFER,
    WR_RESP
  } state_e;

  typedef enum logic [1:0] {
    GNT_INST,
    GNT_DRD,
    GNT_DWR
  } gnt_e;

  // Which master port owned the most recently completed transaction.
  typedef enum logic {
    GNT_IPORT = 1'b0,
    GNT_DATA  = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester picker: fixed priority to b, or round-robin against the last winner.
module arb_pick2 (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last,    // 1: b won the previous round
  input  logic       prio_b,
  output logic [1:0] gnt      // one-hot, gnt[0]=a, gnt[1]=b
);

  always_comb begin
    gnt = 2'b00;
    if (req_a && req_b) begin
      gnt = (prio_b || !last) ? 2'b10 : 2'b01;
    end else if (req_a) begin
      gnt = 2'b01;
    end else if (req_b) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/axil_mem_arbiter.sv
// Fetch + data AXI4-Lite masters onto one slave, one transaction outstanding,
// grant held until the response handshake.
module axil_mem_arbiter
  import axil_arb_defs::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DATA_PRIO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   inst_araddr,
  input  logic                inst_arvalid,
  output logic                inst_arready,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic [1:0]          inst_rresp,
  output logic                inst_rvalid,
  input  logic                inst_rready,
  input  logic [ADDR_W-1:0]   data_araddr,
  input  logic                data_arvalid,
  output logic                data_arready,
  output logic [DATA_W-1:0]   data_rdata,
  output logic [1:0]          data_rresp,
  output logic                data_rvalid,
  input  logic                data_rready,
  input  logic [ADDR_W-1:0]   data_awaddr,
  input  logic                data_awvalid,
  output logic                data_awready,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic                data_wvalid,
  output logic                data_wready,
  output logic [1:0]          data_bresp,
  output logic                data_bvalid,
  input  logic                data_bready,
  output logic [ADDR_W-1:0]   mem_araddr,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_rresp,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  output logic [ADDR_W-1:0]   mem_awaddr,
  output logic                mem_awvalid,
  input  logic                mem_awready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  input  logic [1:0]          mem_bresp,
  input  logic                mem_bvalid,
  output logic                mem_bready
);

  state_e     state_q, state_d;
  gnt_e       gnt_q, gnt_d;
  port_e      last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [1:0] pick;
  logic       gnt_inst;
  logic       req_dwr;
  logic       aw_all;
  logic       w_all;

  assign req_dwr  = data_awvalid | data_wvalid;
  assign gnt_inst = (gnt_q == GNT_INST);

  arb_pick2 u_pick (
    .req_a  (inst_arvalid),
    .req_b  (data_arvalid | req_dwr),
    .last   (last_q == GNT_DATA),
    .prio_b (DATA_PRIO != 0),
    .gnt    (pick)
  );

  // Payloads are passed straight through; only valid/ready are gated by the grant.
  assign mem_araddr = gnt_inst ? inst_araddr : data_araddr;
  assign mem_awaddr = data_awaddr;
  assign mem_wdata  = data_wdata;
  assign mem_wstrb  = data_wstrb;
  assign inst_rdata = mem_rdata;
  assign inst_rresp = mem_rresp;
  assign data_rdata = mem_rdata;
  assign data_rresp = mem_rresp;
  assign data_bresp = mem_bresp;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    inst_arready = 1'b0;
    inst_rvalid  = 1'b0;
    data_arready = 1'b0;
    data_rvalid  = 1'b0;
    data_awready = 1'b0;
    data_wready  = 1'b0;
    data_bvalid  = 1'b0;
    mem_arvalid  = 1'b0;
    mem_rready   = 1'b0;
    mem_awvalid  = 1'b0;
    mem_wvalid   = 1'b0;
    mem_bready   = 1'b0;
    aw_all       = 1'b0;
    w_all        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick[1]) begin
          // Store beats a simultaneous load from the same port.
          gnt_d   = req_dwr ? GNT_DWR : GNT_DRD;
          state_d = req_dwr ? WR_XFER : RD_ADDR;
        end else if (pick[0]) begin
          gnt_d   = GNT_INST;
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        mem_arvalid  = gnt_inst ? inst_arvalid : data_arvalid;
        inst_arready = gnt_inst & mem_arready;
        data_arready = ~gnt_inst & mem_arready;
        if (mem_arvalid && mem_arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        inst_rvalid = gnt_inst & mem_rvalid;
        data_rvalid = ~gnt_inst & mem_rvalid;
        mem_rready  = gnt_inst ? inst_rready : data_rready;
        if (mem_rvalid && mem_rready) begin
          state_d = IDLE;
          last_d  = gnt_inst ? GNT_IPORT : GNT_DATA;
        end
      end
      WR_XFER: begin
        mem_awvalid  = data_awvalid & ~aw_done_q;
        mem_wvalid   = data_wvalid & ~w_done_q;
        data_awready = mem_awready & ~aw_done_q;
        data_wready  = mem_wready & ~w_done_q;
        aw_all       = aw_done_q | (mem_awvalid & mem_awready);
        w_all        = w_done_q | (mem_wvalid & mem_wready);
        if (aw_all && w_all) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_all;
          w_done_d  = w_all;
        end
      end
      WR_RESP: begin
        data_bvalid = mem_bvalid;
        mem_bready  = data_bready;
        if (mem_bvalid && mem_bready) begin
          state_d = IDLE;
          last_d  = GNT_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_INST;
      last_q    <= GNT_DATA;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Directed bench: instance 0 has fixed data priority, instance 1 round-robin;
// both share master stimulus and each has its own zero-wait slave.
module tb_axil_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_araddr, data_araddr, data_awaddr, data_wdata;
  logic        inst_arvalid, inst_rready, data_arvalid, data_rready;
  logic        data_awvalid, data_wvalid, data_bready;
  logic [3:0]  data_wstrb;
  logic [1:0]  rresp_cfg, bresp_cfg;

  logic        inst_arready [2];
  logic [31:0] inst_rdata   [2];
  logic [1:0]  inst_rresp   [2];
  logic        inst_rvalid  [2];
  logic        data_arready [2];
  logic [31:0] data_rdata   [2];
  logic [1:0]  data_rresp   [2];
  logic        data_rvalid  [2];
  logic        data_awready [2];
  logic        data_wready  [2];
  logic [1:0]  data_bresp   [2];
  logic        data_bvalid  [2];
  logic [31:0] mem_araddr   [2];
  logic        mem_arvalid  [2];
  logic        mem_arready  [2];
  logic [31:0] mem_rdata    [2];
  logic [1:0]  mem_rresp    [2];
  logic        mem_rvalid   [2];
  logic        mem_rready   [2];
  logic [31:0] mem_awaddr   [2];
  logic        mem_awvalid  [2];
  logic        mem_awready  [2];
  logic [31:0] mem_wdata    [2];
  logic [3:0]  mem_wstrb    [2];
  logic        mem_wvalid   [2];
  logic        mem_wready   [2];
  logic [1:0]  mem_bresp    [2];
  logic        mem_bvalid   [2];
  logic        mem_bready   [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        r_pend, aw_seen, w_seen, b_pend;
    logic [31:0] r_addr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    axil_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO((g == 0) ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .inst_araddr(inst_araddr), .inst_arvalid(inst_arvalid), .inst_arready(inst_arready[g]),
      .inst_rdata(inst_rdata[g]), .inst_rresp(inst_rresp[g]), .inst_rvalid(inst_rvalid[g]),
      .inst_rready(inst_rready),
      .data_araddr(data_araddr), .data_arvalid(data_arvalid), .data_arready(data_arready[g]),
      .data_rdata(data_rdata[g]), .data_rresp(data_rresp[g]), .data_rvalid(data_rvalid[g]),
      .data_rready(data_rready),
      .data_awaddr(data_awaddr), .data_awvalid(data_awvalid), .data_awready(data_awready[g]),
      .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_wvalid(data_wvalid),
      .data_wready(data_wready[g]),
      .data_bresp(data_bresp[g]), .data_bvalid(data_bvalid[g]), .data_bready(data_bready),
      .mem_araddr(mem_araddr[g]), .mem_arvalid(mem_arvalid[g]), .mem_arready(mem_arready[g]),
      .mem_rdata(mem_rdata[g]), .mem_rresp(mem_rresp[g]), .mem_rvalid(mem_rvalid[g]),
      .mem_rready(mem_rready[g]),
      .mem_awaddr(mem_awaddr[g]), .mem_awvalid(mem_awvalid[g]), .mem_awready(mem_awready[g]),
      .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]), .mem_wvalid(mem_wvalid[g]),
      .mem_wready(mem_wready[g]),
      .mem_bresp(mem_bresp[g]), .mem_bvalid(mem_bvalid[g]), .mem_bready(mem_bready[g])
    );

    // Zero-wait slave: read data is the address offset from 0x8000_0000 plus 0x13.
    assign mem_arready[g] = 1'b1;
    assign mem_awready[g] = 1'b1;
    assign mem_wready[g]  = 1'b1;
    assign mem_rvalid[g]  = r_pend;
    assign mem_rdata[g]   = r_addr - 32'h8000_0000 + 32'h13;
    assign mem_rresp[g]   = rresp_cfg;
    assign mem_bvalid[g]  = b_pend;
    assign mem_bresp[g]   = bresp_cfg;

    always @(posedge clk) begin
      if (rst) begin
        r_pend  <= 1'b0;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
        b_pend  <= 1'b0;
      end else begin
        if (mem_arvalid[g]) begin
          r_pend <= 1'b1;
          r_addr <= mem_araddr[g];
        end else if (r_pend && mem_rready[g]) begin
          r_pend <= 1'b0;
        end
        if (mem_awvalid[g]) begin
          aw_seen    <= 1'b1;
          cap_awaddr <= mem_awaddr[g];
        end
        if (mem_wvalid[g]) begin
          w_seen    <= 1'b1;
          cap_wdata <= mem_wdata[g];
          cap_wstrb <= mem_wstrb[g];
        end
        if ((aw_seen || mem_awvalid[g]) && (w_seen || mem_wvalid[g])) begin
          b_pend  <= 1'b1;
          aw_seen <= 1'b0;
          w_seen  <= 1'b0;
        end
        if (b_pend && mem_bready[g]) b_pend <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] vr(input bit i);
    return {inst_arready[i], inst_rvalid[i], data_arready[i], data_rvalid[i],
            data_awready[i], data_wready[i], data_bvalid[i], mem_arvalid[i],
            mem_rready[i], mem_awvalid[i], mem_wvalid[i], mem_bready[i]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    inst_araddr  = '0; inst_arvalid = 1'b0; inst_rready = 1'b1;
    data_araddr  = '0; data_arvalid = 1'b0; data_rready = 1'b1;
    data_awaddr  = '0; data_awvalid = 1'b0;
    data_wdata   = '0; data_wstrb   = '0;   data_wvalid = 1'b0;
    data_bready  = 1'b1;
    rresp_cfg    = 2'b00; bresp_cfg = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  int oq0[$];
  int oq1[$];
  int exp_rr[$] = '{0, 1, 0, 1};

  initial begin
    // Reset state
    do_reset();
    settle();
    chk("rst_idle_p", 64'(vr(1'b0)), 64'h0);
    chk("rst_idle_rr", 64'(vr(1'b1)), 64'h0);

    // Single fetch
    do_reset();
    inst_araddr = 32'h8000_0000; inst_arvalid = 1'b1; settle();
    chk("fetch_c0_arvalid", 64'(mem_arvalid[0]), 64'h0);
    cyc(); settle();
    chk("fetch_c1_arvalid", 64'(mem_arvalid[0]), 64'h1);
    chk("fetch_c1_araddr", 64'(mem_araddr[0]), 64'h8000_0000);
    chk("fetch_c1_arready", 64'(inst_arready[0]), 64'h1);
    cyc(); inst_arvalid = 1'b0; settle();
    chk("fetch_c2_rvalid", 64'(inst_rvalid[0]), 64'h1);
    chk("fetch_c2_rdata", 64'(inst_rdata[0]), 64'h13);
    cyc(); settle();
    chk("fetch_c3_idle", 64'(vr(1'b0)), 64'h0);

    // Tie under fixed data priority
    do_reset();
    inst_araddr = 32'h8000_0004; inst_arvalid = 1'b1;
    data_araddr = 32'h8000_1000; data_arvalid = 1'b1; settle();
    cyc(); settle();
    chk("tie_c1_araddr", 64'(mem_araddr[0]), 64'h8000_1000);
    chk("tie_c1_darready", 64'(data_arready[0]), 64'h1);
    chk("tie_c1_iarready", 64'(inst_arready[0]), 64'h0);
    cyc(); data_arvalid = 1'b0; settle();
    chk("tie_c2_drvalid", 64'(data_rvalid[0]), 64'h1);
    chk("tie_c2_drdata", 64'(data_rdata[0]), 64'h1013);
    chk("tie_c2_iarready", 64'(inst_arready[0]), 64'h0);
    chk("tie_c2_irvalid", 64'(inst_rvalid[0]), 64'h0);
    cyc(); settle();
    chk("tie_c3_idle", 64'(mem_arvalid[0]), 64'h0);
    cyc(); settle();
    chk("tie_c4_araddr", 64'(mem_araddr[0]), 64'h8000_0004);
    chk("tie_c4_iarready", 64'(inst_arready[0]), 64'h1);
    cyc(); inst_arvalid = 1'b0; settle();
    chk("tie_c5_irvalid", 64'(inst_rvalid[0]), 64'h1);
    chk("tie_c5_irdata", 64'(inst_rdata[0]), 64'h17);

    // Continuous requests: round-robin alternates, fixed priority starves fetch
    do_reset();
    inst_araddr = 32'h8000_0000; inst_arvalid = 1'b1;
    data_araddr = 32'h8000_1000; data_arvalid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (inst_rvalid[0]) oq0.push_back(0);
      if (data_rvalid[0]) oq0.push_back(1);
      if (inst_rvalid[1]) oq1.push_back(0);
      if (data_rvalid[1]) oq1.push_back(1);
      cyc();
    end
    chk("rr_count", 64'(oq1.size()), 64'd4);
    chk("prio_count", 64'(oq0.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_order_%0d", k), 64'((k < oq1.size()) ? oq1[k] : 99), 64'(exp_rr[k]));
      chk($sformatf("prio_order_%0d", k), 64'((k < oq0.size()) ? oq0[k] : 99), 64'd1);
    end

    // Staggered write: AW first, W two cycles later
    do_reset();
    bresp_cfg = 2'b11;
    data_awaddr = 32'h8000_2000; data_awvalid = 1'b1; settle();
    cyc(); settle();
    chk("wr_c1_awvalid", 64'(mem_awvalid[0]), 64'h1);
    chk("wr_c1_awready", 64'(data_awready[0]), 64'h1);
    chk("wr_c1_wvalid", 64'(mem_wvalid[0]), 64'h0);
    cyc(); settle();
    chk("wr_c2_awvalid", 64'(mem_awvalid[0]), 64'h0);
    chk("wr_c2_awready", 64'(data_awready[0]), 64'h0);
    cyc();
    data_awvalid = 1'b0; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011; data_wvalid = 1'b1;
    settle();
    chk("wr_c3_wvalid", 64'(mem_wvalid[0]), 64'h1);
    chk("wr_c3_wready", 64'(data_wready[0]), 64'h1);
    chk("wr_c3_wstrb", 64'(mem_wstrb[0]), 64'h3);
    cyc(); data_wvalid = 1'b0; settle();
    chk("wr_c4_bvalid", 64'(data_bvalid[0]), 64'h1);
    chk("wr_c4_bresp", 64'(data_bresp[0]), 64'h3);
    chk("wr_c4_bready", 64'(mem_bready[0]), 64'h1);
    chk("wr_mem_awaddr", 64'(g_dut[0].cap_awaddr), 64'h8000_2000);
    chk("wr_mem_wdata", 64'(g_dut[0].cap_wdata), 64'hDEAD_BEEF);
    chk("wr_mem_wstrb", 64'(g_dut[0].cap_wstrb), 64'h3);
    cyc(); settle();
    chk("wr_c5_idle", 64'(vr(1'b0)), 64'h0);

    // Backpressure with SLVERR
    do_reset();
    rresp_cfg = 2'b10;
    data_araddr = 32'h8000_0040; data_arvalid = 1'b1; data_rready = 1'b0; settle();
    cyc(); settle();
    cyc(); data_arvalid = 1'b0; settle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_rvalid_%0d", k), 64'(data_rvalid[0]), 64'h1);
      chk($sformatf("bp_rready_%0d", k), 64'(mem_rready[0]), 64'h0);
      cyc(); settle();
    end
    data_rready = 1'b1; settle();
    chk("bp_rready_rel", 64'(mem_rready[0]), 64'h1);
    chk("bp_rresp", 64'(data_rresp[0]), 64'h2);
    chk("bp_rdata", 64'(data_rdata[0]), 64'h53);
    cyc(); settle();
    chk("bp_done", 64'(data_rvalid[0]), 64'h0);

    // Reset while a fetch response is pending
    do_reset();
    inst_araddr = 32'h8000_0000; inst_arvalid = 1'b1; inst_rready = 1'b0; settle();
    cyc(); settle();
    cyc(); inst_arvalid = 1'b0; settle();
    chk("rstmid_pre_rvalid", 64'(inst_rvalid[0]), 64'h1);
    rst = 1'b1;
    cyc(); rst = 1'b0; settle();
    chk("rstmid_idle_p", 64'(vr(1'b0)), 64'h0);
    chk("rstmid_idle_rr", 64'(vr(1'b1)), 64'h0);
    inst_rready = 1'b1; inst_araddr = 32'h8000_0008; inst_arvalid = 1'b1; settle();
    cyc(); settle();
    chk("rstmid_arready", 64'(inst_arready[0]), 64'h1);
    cyc(); inst_arvalid = 1'b0; settle();
    chk("rstmid_rvalid", 64'(inst_rvalid[0]), 64'h1);
    chk("rstmid_rdata", 64'(inst_rdata[0]), 64'h1b);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
